// File: rtl/tick_gen_pkg.sv
// Shared types and board divisor constants for the tick generator.
// Divisors assume a 100 MHz system clock; the period of a channel is D+1 cycles.
package tick_gen_pkg;

    localparam int CNT_W_DEF = 28;

    typedef logic [CNT_W_DEF-1:0] div_t;

    localparam div_t DIV_1HZ  = 28'd99_999_999;
    localparam div_t DIV_10HZ = 28'd9_999_999;
    localparam div_t DIV_20HZ = 28'd4_999_999;
    localparam div_t DIV_40HZ = 28'd2_499_999;
    localparam div_t DIV_SCAN = 28'd2_499;

endpackage

// File: rtl/tick_chan.sv
// One tick channel: wrap counter, shadow divisor with pending flag, optional square wave.
// The square-wave flop exists only when TICK_GEN_SQUARE_EN is defined; otherwise sq is tied low.
module tick_chan
    import tick_gen_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DIV_RST = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load_now,
    input  logic             load_defer,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             tick,
    output logic             sq,
    output logic             pend
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] shadow;
    logic             wrap;

    assign wrap = en && (cnt == div);

    // An immediate load overrides counting but the wrap tick of that cycle still fires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            div    <= DIV_RST;
            shadow <= '0;
            pend   <= 1'b0;
            tick   <= 1'b0;
        end else begin
            tick <= wrap;
            if (load_now) begin
                div  <= cfg_div;
                cnt  <= '0;
                pend <= 1'b0;
            end else begin
                if (wrap) begin
                    cnt <= '0;
                end else if (en) begin
                    cnt <= cnt + 1'b1;
                end
                if (load_defer) begin
                    shadow <= cfg_div;
                    pend   <= 1'b1;
                end else if (wrap && pend) begin
                    div  <= shadow;
                    pend <= 1'b0;
                end
            end
        end
    end

`ifdef TICK_GEN_SQUARE_EN
    // Toggling on the same edge that registers tick gives an exact 50 % duty cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq <= 1'b0;
        end else if (wrap) begin
            sq <= ~sq;
        end
    end
`else
    assign sq = 1'b0;
`endif

endmodule

// File: rtl/tick_gen.sv
// Multi-channel synchronous tick generator with a valid/ready divisor config port.
// Define TICK_GEN_SQUARE_EN to build the per-channel 50 % square-wave outputs.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int                        CHANNELS = 6,
    parameter int                        CNT_W    = CNT_W_DEF,
    parameter logic [CHANNELS*CNT_W-1:0] DIV_INIT = {CHANNELS{CNT_W'(DIV_1HZ)}},
    localparam int                       CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [CNT_W-1:0]    cfg_div,
    input  logic                cfg_now,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] sq
);

    logic [CHANNELS-1:0]    pend;
    logic [(1<<CH_W)-1:0]   pend_pad;
    logic                   accept;

    // Unused channel codes read as never-pending, so out-of-range requests are taken and dropped.
    always_comb begin
        pend_pad                 = '0;
        pend_pad[CHANNELS-1:0]   = pend;
    end

    assign cfg_ready = !pend_pad[cfg_chan];
    assign accept    = cfg_valid && cfg_ready;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic sel;
        assign sel = accept && (cfg_chan == CH_W'(i));

        tick_chan #(
            .CNT_W   (CNT_W),
            .DIV_RST (DIV_INIT[i*CNT_W +: CNT_W])
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .load_now   (sel && cfg_now),
            .load_defer (sel && !cfg_now),
            .cfg_div    (cfg_div),
            .tick       (tick[i]),
            .sq         (sq[i]),
            .pend       (pend[i])
        );
    end

endmodule

// File: tb/tb_tick_gen.sv
// Directed bench for tick_gen: 3 channels, 8-bit divisors, reset divisors {2, 0, 4}.
// Square-wave expectations follow TICK_GEN_SQUARE_EN when it is defined for the build.
module tb_tick_gen;

`ifdef TICK_GEN_SQUARE_EN
    localparam bit SQ_ON = 1'b1;
`else
    localparam bit SQ_ON = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [1:0] cfg_chan;
    logic [7:0] cfg_div;
    logic       cfg_now;
    logic [2:0] tick;
    logic [2:0] sq;

    int errors = 0;
    int checks = 0;

    tick_gen #(
        .CHANNELS (3),
        .CNT_W    (8),
        .DIV_INIT ({8'd2, 8'd0, 8'd4})
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_div   (cfg_div),
        .cfg_now   (cfg_now),
        .tick      (tick),
        .sq        (sq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input logic [1:0] chan, input logic [7:0] div, input logic now);
        cfg_valid = valid;
        cfg_chan  = chan;
        cfg_div   = div;
        cfg_now   = now;
    endtask

    task automatic step_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [15:0] exp0;
    logic [15:0] exp2;

    initial begin
        exp0 = 16'h5510;
        exp2 = 16'h4124;
        rst = 1'b1;
        en  = 1'b1;
        apply_stimulus(1'b0, 2'd0, 8'd0, 1'b0);
        #2;
        check_output("reset_tick", tick, 3'b000);
        check_output("reset_sq", sq, 3'b000);
        check_output("reset_ready", cfg_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;

        // Free running from reset: D=4, D=0, D=2.
        for (int k = 1; k <= 15; k++) begin
            step_edges(1);
            check_output($sformatf("a_tick0@%0d", k), tick[0], (k % 5) == 0);
            check_output($sformatf("a_tick1@%0d", k), tick[1], 1'b1);
            check_output($sformatf("a_tick2@%0d", k), tick[2], (k % 3) == 0);
        end

        // Immediate D=3 on ch0, deferred D=1, blocked request, other-channel load on a wrap.
        apply_stimulus(1'b1, 2'd0, 8'd3, 1'b1);
        #1 check_output("b_ready_now", cfg_ready, 1'b1);
        for (int k = 16; k <= 31; k++) begin
            step_edges(1);
            check_output($sformatf("b_tick0@%0d", k), tick[0], exp0[k-16]);
            check_output($sformatf("b_tick1@%0d", k), tick[1], 1'b1);
            check_output($sformatf("b_tick2@%0d", k), tick[2], exp2[k-16]);
            case (k)
                16: cfg_valid = 1'b0;
                21: begin
                    apply_stimulus(1'b1, 2'd0, 8'd1, 1'b0);
                    #1 check_output("b_ready_defer", cfg_ready, 1'b1);
                end
                22: begin
                    apply_stimulus(1'b0, 2'd3, 8'd0, 1'b0);
                    #1 check_output("b_ready_oob", cfg_ready, 1'b1);
                    apply_stimulus(1'b1, 2'd0, 8'd6, 1'b1);
                    #1 check_output("b_ready_pend22", cfg_ready, 1'b0);
                end
                23: begin
                    check_output("b_ready_pend23", cfg_ready, 1'b0);
                    apply_stimulus(1'b1, 2'd2, 8'd5, 1'b1);
                    #1 check_output("b_ready_other", cfg_ready, 1'b1);
                end
                24: begin
                    apply_stimulus(1'b0, 2'd0, 8'd0, 1'b0);
                    #1 check_output("b_ready_after_wrap", cfg_ready, 1'b1);
                end
                default: ;
            endcase
        end

        // Immediate D=4 on a wrap of D=1, then en low for 7 cycles at cnt=2.
        apply_stimulus(1'b1, 2'd0, 8'd4, 1'b1);
        #1 check_output("c_ready_now", cfg_ready, 1'b1);
        for (int k = 32; k <= 45; k++) begin
            step_edges(1);
            check_output($sformatf("c_tick0@%0d", k), tick[0], (k == 32) || (k == 44));
            check_output($sformatf("c_tick1@%0d", k), tick[1], !((k >= 35) && (k <= 41)));
            case (k)
                32: cfg_valid = 1'b0;
                34: begin
                    en = 1'b0;
                    #1 check_output("c_inflight_tick1", tick[1], 1'b1);
                end
                41: en = 1'b1;
                default: ;
            endcase
        end

        // Fresh reset: square waves, then asynchronous reset while ch0 is pending and sq0 high.
        rst = 1'b1;
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            step_edges(1);
            check_output($sformatf("d_sq0@%0d", k), sq[0],
                         SQ_ON && (((k >= 5) && (k <= 9)) || (k >= 15)));
            check_output($sformatf("d_sq1@%0d", k), sq[1], SQ_ON && ((k % 2) == 1));
            if (k == 16) begin
                apply_stimulus(1'b1, 2'd0, 8'd9, 1'b0);
            end
        end
        cfg_valid = 1'b0;
        check_output("d_ready_pend", cfg_ready, 1'b0);
        check_output("d_tick1_pre", tick[1], 1'b1);
        #2 rst = 1'b1;
        #1;
        check_output("d_async_tick", tick, 3'b000);
        check_output("d_async_sq", sq, 3'b000);
        check_output("d_async_ready", cfg_ready, 1'b1);
        step_edges(1);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
